// File: rtl/wb_pkg.sv
// Shared widths, constants and the long-path result entry type for the
// register write-back block.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Register 0 is hardwired to zero: writes to it are dropped, it never hazards.
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (head, show-ahead),
//        full, empty, count (0..DEPTH).
// Push while full and pop while empty are ignored. DEPTH must be a power of 2.
module wb_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  wb_pkg::wb_entry_t           din,
    input  logic                        pop,
    output wb_pkg::wb_entry_t           dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    import wb_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register file write-back merger and pending-write scoreboard.
// Merges single-cycle ALU results (strict priority, no backpressure) and
// buffered long-path results onto one registered write port, and tracks
// registers with outstanding long-path writes for hazard detection.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_waddr/alu_wdata ALU result
//   mem_valid/mem_ready/mem_waddr/mem_wdata  long-path result handshake
//   pend_set/pend_addr            mark a destination busy at long-op issue
//   raddr1/raddr2 -> hzd1/hzd2    source hazard flags (combinational)
//   busy                          scoreboard vector
//   fifo_cnt                      buffered long-path entries
//   we/waddr/wdata                register file write port (registered)
// Optional build macro WB_BYPASS_EN adds rf_rdata1/2 inputs and
// fwd_rdata1/2 outputs forwarding the in-flight write to readers.
module reg_writeback #(
    parameter int unsigned DATA_W     = wb_pkg::DATA_W,
    parameter int unsigned ADDR_W     = wb_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_waddr,
    input  logic [DATA_W-1:0]             alu_wdata,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_W-1:0]             mem_waddr,
    input  logic [DATA_W-1:0]             mem_wdata,
    input  logic                          pend_set,
    input  logic [ADDR_W-1:0]             pend_addr,
    input  logic [ADDR_W-1:0]             raddr1,
    input  logic [ADDR_W-1:0]             raddr2,
    output logic                          hzd1,
    output logic                          hzd2,
    output logic [(1<<ADDR_W)-1:0]        busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          we,
    output logic [ADDR_W-1:0]             waddr,
    output logic [DATA_W-1:0]             wdata
`ifdef WB_BYPASS_EN
    ,
    input  logic [DATA_W-1:0]             rf_rdata1,
    input  logic [DATA_W-1:0]             rf_rdata2,
    output logic [DATA_W-1:0]             fwd_rdata1,
    output logic [DATA_W-1:0]             fwd_rdata2
`endif
);
    import wb_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned NREG  = 1 << ADDR_W;

    wb_entry_t         push_entry;
    wb_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              alu_win;
    logic              ready_en;
    logic [NREG-1:0]   busy_nxt;

    // Holds mem_ready low through reset and releases it one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Readiness looks only at the registered count; a same-cycle pop does not help.
    assign mem_ready = ready_en && (fifo_cnt < CNT_W'(FIFO_DEPTH));

    // Writes to r0 complete the handshake but are not buffered.
    assign push       = mem_valid && mem_ready && (mem_waddr != ZERO_REG);
    assign push_entry = '{addr: mem_waddr, data: mem_wdata};

    assign alu_win = alu_valid && (alu_waddr != ZERO_REG);
    assign pop     = !alu_win && !fifo_empty;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Write port: ALU first, then FIFO head; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (alu_win) begin
            we    <= 1'b1;
            waddr <= alu_waddr;
            wdata <= alu_wdata;
        end else if (pop) begin
            we    <= 1'b1;
            waddr <= head.addr;
            wdata <= head.data;
        end else begin
            we    <= 1'b0;
        end
    end

    // Scoreboard update: pop clears, issue sets (set applied last so it wins).
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head.addr] = 1'b0;
        end
        if (pend_set && (pend_addr != ZERO_REG)) begin
            busy_nxt[pend_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign hzd1 = busy[raddr1];
    assign hzd2 = busy[raddr2];

`ifdef WB_BYPASS_EN
    // Forward the write that the register file has not yet committed.
    assign fwd_rdata1 = (we && (waddr == raddr1) && (raddr1 != ZERO_REG)) ? wdata : rf_rdata1;
    assign fwd_rdata2 = (we && (waddr == raddr2) && (raddr2 != ZERO_REG)) ? wdata : rf_rdata2;
`endif

    // fifo_full is implied by fifo_cnt; kept for visibility at this level.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        hzd1;
    logic        hzd2;
    logic [31:0] busy;
    logic [2:0]  fifo_cnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_BYPASS_EN
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] fwd_rdata1;
    logic [31:0] fwd_rdata2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_writeback #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .hzd1      (hzd1),
        .hzd2      (hzd2),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
`ifdef WB_BYPASS_EN
        ,
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .fwd_rdata1 (fwd_rdata1),
        .fwd_rdata2 (fwd_rdata2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        alu_valid = 1'b0;
        alu_waddr = '0;
        alu_wdata = '0;
        mem_valid = 1'b1;
        mem_waddr = 5'd3;
        mem_wdata = 32'h33;
        pend_set  = 1'b0;
        pend_addr = '0;
        raddr1    = '0;
        raddr2    = '0;
`ifdef WB_BYPASS_EN
        rf_rdata1 = '0;
        rf_rdata2 = '0;
`endif

        // Reset held two cycles with a long-path offer present.
        step();
        check("rst_ready_low", 32'(mem_ready), 32'd0);
        step();
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        rst       = 1'b0;
        mem_valid = 1'b0;
        step();
        check("rel_ready", 32'(mem_ready), 32'd1);
        check("rel_cnt", 32'(fifo_cnt), 32'd0);
        check("rel_we", 32'(we), 32'd0);

        // Single ALU write, then a dropped write to r0.
        alu_valid = 1'b1;
        alu_waddr = 5'd5;
        alu_wdata = 32'hDEADBEEF;
        step();
        check("alu_we", 32'(we), 32'd1);
        check("alu_waddr", 32'(waddr), 32'd5);
        check("alu_wdata", wdata, 32'hDEADBEEF);
        alu_waddr = 5'd0;
        alu_wdata = 32'h1234;
        step();
        check("alu_r0_we", 32'(we), 32'd0);
        check("alu_r0_hold_addr", 32'(waddr), 32'd5);
        check("alu_r0_hold_data", wdata, 32'hDEADBEEF);
        alu_valid = 1'b0;

        // r0 can never become busy.
        pend_set  = 1'b1;
        pend_addr = 5'd0;
        step();
        check("busy_r0", busy, 32'd0);

        // Contention: r7 pending, long result waits behind 3 ALU writes.
        pend_addr = 5'd7;
        step();
        pend_set = 1'b0;
        check("pend_busy7", busy, 32'h80);
        raddr1 = 5'd7;
        raddr2 = 5'd0;
        #1;
        check("hzd1_set", 32'(hzd1), 32'd1);
        check("hzd2_r0", 32'(hzd2), 32'd0);
        alu_valid = 1'b1;
        alu_waddr = 5'd3;
        alu_wdata = 32'hA3;
        mem_valid = 1'b1;
        mem_waddr = 5'd7;
        mem_wdata = 32'h11;
        step();
        mem_valid = 1'b0;
        check("cont_w1_addr", 32'(waddr), 32'd3);
        check("cont_cnt", 32'(fifo_cnt), 32'd1);
        step();
        check("cont_w2_addr", 32'(waddr), 32'd3);
        step();
        check("cont_w3_addr", 32'(waddr), 32'd3);
        check("cont_w3_we", 32'(we), 32'd1);
        check("cont_hzd_held", 32'(hzd1), 32'd1);
        alu_valid = 1'b0;
        step();
        check("cont_mem_we", 32'(we), 32'd1);
        check("cont_mem_addr", 32'(waddr), 32'd7);
        check("cont_mem_data", wdata, 32'h11);
        check("cont_busy_clr", busy, 32'd0);
        check("cont_hzd_clr", 32'(hzd1), 32'd0);
        check("cont_cnt_empty", 32'(fifo_cnt), 32'd0);

        // Backpressure: ALU every cycle, fill the FIFO, 5th offer is held.
        alu_valid = 1'b1;
        alu_waddr = 5'd1;
        alu_wdata = 32'hF1;
        mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_waddr = 5'(10 + i);
            mem_wdata = 32'h100 + 32'(i);
            step();
        end
        check("bp_cnt_full", 32'(fifo_cnt), 32'd4);
        check("bp_ready_low", 32'(mem_ready), 32'd0);
        mem_waddr = 5'd14;
        mem_wdata = 32'h104;
        step();
        step();
        check("bp_cnt_held", 32'(fifo_cnt), 32'd4);
        check("bp_alu_addr", 32'(waddr), 32'd1);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_drain_we", 32'(we), 32'd1);
            check("bp_drain_addr", 32'(waddr), 32'(10 + i));
            check("bp_drain_data", wdata, 32'h100 + 32'(i));
        end
        step();
        check("bp_idle_we", 32'(we), 32'd0);
        check("bp_idle_cnt", 32'(fifo_cnt), 32'd0);

        // Set/clear collision on r9: set wins.
        pend_set  = 1'b1;
        pend_addr = 5'd9;
        step();
        pend_set  = 1'b0;
        mem_valid = 1'b1;
        mem_waddr = 5'd9;
        mem_wdata = 32'h99;
        step();
        mem_valid = 1'b0;
        pend_set  = 1'b1;
        step();
        pend_set = 1'b0;
        check("coll_we_addr", 32'(waddr), 32'd9);
        check("coll_busy9", busy, 32'h200);
        // A plain pop of r9 clears it.
        mem_valid = 1'b1;
        mem_wdata = 32'h9A;
        step();
        mem_valid = 1'b0;
        step();
        check("clr9_data", wdata, 32'h9A);
        check("clr9_busy", busy, 32'd0);

        // Reset with 3 entries buffered and r20 pending.
        alu_valid = 1'b1;
        alu_waddr = 5'd1;
        pend_set  = 1'b1;
        pend_addr = 5'd20;
        mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_waddr = 5'(20 + i);
            mem_wdata = 32'h200 + 32'(i);
            step();
        end
        check("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
        check("pre_rst_busy", busy, 32'h0010_0000);
        alu_valid = 1'b0;
        pend_set  = 1'b0;
        mem_valid = 1'b0;
        rst       = 1'b1;
        step();
        check("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_we", 32'(we), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_we1", 32'(we), 32'd0);
        step();
        check("post_rst_we2", 32'(we), 32'd0);
        check("post_rst_cnt", 32'(fifo_cnt), 32'd0);

`ifdef WB_BYPASS_EN
        // Forwarding of the not-yet-committed write.
        alu_valid = 1'b1;
        alu_waddr = 5'd4;
        alu_wdata = 32'h55;
        step();
        alu_valid = 1'b0;
        raddr1    = 5'd4;
        rf_rdata1 = 32'h0;
        raddr2    = 5'd6;
        rf_rdata2 = 32'h66;
        #1;
        check("fwd1_hit", fwd_rdata1, 32'h55);
        check("fwd2_miss", fwd_rdata2, 32'h66);
        raddr1    = 5'd0;
        rf_rdata1 = 32'h77;
        raddr2    = 5'd4;
        rf_rdata2 = 32'h9;
        #1;
        check("fwd1_r0", fwd_rdata1, 32'h77);
        check("fwd2_hit", fwd_rdata2, 32'h55);
        step();
        check("fwd_no_we", fwd_rdata2, 32'h9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write-side companion of the 32x32 register file. It merges results from the single-cycle ALU path and the handshaked load/long-latency path onto the register file's single write port (we/waddr/wdata). It also keeps a pending-write scoreboard so issue logic can stall on read-after-write hazards. It sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, result/register data width
ADDR_W, 5, register address width (32 registers)
FIFO_DEPTH, 4, long-path result buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle (no backpressure)
alu_waddr  in  ADDR_W  ALU destination register
alu_wdata  in  DATA_W  ALU result
mem_valid  in  1  long-path result offered
mem_ready  out  1  long-path result accepted when mem_valid&mem_ready
mem_waddr  in  ADDR_W  long-path destination register
mem_wdata  in  DATA_W  long-path result
pend_set  in  1  long op issued; mark pend_addr busy
pend_addr  in  ADDR_W  destination of issued long op
raddr1, raddr2  in  ADDR_W  issue-stage source registers
hzd1, hzd2  out  1  source register has a pending long-path write
busy  out  32  scoreboard bit vector
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  buffered entries
we  out  1  register file write enable
waddr  out  ADDR_W  register file write address
wdata  out  DATA_W  register file write data

Behaviour:
- Reset (rst=1 at edge): we=0, waddr=0, wdata=0, FIFO emptied (fifo_cnt=0), busy=0. Any in-flight entry is discarded. mem_ready goes to 1 the cycle after rst deasserts.
- we/waddr/wdata are registered: 1-cycle latency from the winning source. The register file commits them on the following edge.
- Arbitration each cycle: if alu_valid && alu_waddr!=0, the ALU result is written. Else if FIFO is non-empty, the FIFO head is popped and written. Else we=0 (waddr/wdata hold their last values).
- alu_valid with alu_waddr==0 is dropped and treated as idle, so the FIFO may drain that cycle.
- The ALU has strict priority. Continuous ALU traffic may starve the FIFO, and mem_ready backpressures the long path.
- mem_ready = (fifo_cnt < FIFO_DEPTH), computed from registered count only, with no same-cycle pop lookahead. When full, no push occurs even if a pop happens that cycle.
- Push occurs on mem_valid && mem_ready. If mem_waddr==0 the handshake completes but nothing is pushed.
- Same-cycle push and pop: count unchanged, order preserved (FIFO order = acceptance order).
- Scoreboard:
  - pend_set with pend_addr!=0 sets busy[pend_addr].
  - A FIFO pop clears busy[head.addr] at the same edge we is loaded.
  - If set and clear hit the same address in one cycle, set wins.
  - busy[0] is always 0.
- hzd1 = busy[raddr1], hzd2 = busy[raddr2]. These are combinational from registered busy. Address 0 never hazards.
- An ALU write to a busy register does not clear busy. Preventing write-after-write is the issue logic's responsibility.
- The FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
WB_BYPASS_EN:
- Defined: adds inputs rf_rdata1, rf_rdata2 (DATA_W) and outputs fwd_rdata1, fwd_rdata2 (DATA_W).
  - fwd_rdataN = wdata when we && waddr==raddrN && raddrN!=0; otherwise rf_rdataN.
  - This closes the one-cycle gap before the register file commits.
- Undefined: these ports do not exist and no bypass logic is built.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W defaults
  - ZERO_REG constant (5'd0)
  - typedef wb_entry_t {addr, data}
- One sub-module, wb_fifo (sync FIFO of wb_entry_t, DEPTH parameter, push/pop/full/empty/count).
- Arbitration, scoreboard and output registers live in reg_writeback.

Test Plan:
1. Reset sequence: hold rst 2 cycles with mem_valid=1 -> we=0, busy=0, fifo_cnt=0, no push; mem_ready=1 on the first cycle after release.
2. Single ALU write: alu_valid, addr 5, data 0xDEADBEEF -> next cycle we=1, waddr=5, wdata=0xDEADBEEF. With alu_waddr=0 -> we=0.
3. Contention: pend_set r7. Push mem r7=0x11 while ALU writes r3 for 3 cycles -> r3 written for 3 cycles, r7=0x11 written on the 4th. busy[7] and hzd for raddr1=7 stay 1 until that edge, then 0.
4. Backpressure: ALU busy every cycle, push 4 mem results -> fifo_cnt=4, mem_ready=0, 5th offer held. After ALU stops, entries are written in order on 4 consecutive cycles.
5. Set/clear collision: the cycle r9 pops, pend_set r9 is asserted -> busy[9] remains 1. Reset asserted with 3 entries buffered -> fifo_cnt=0, busy=0, no further we.
6. WB_BYPASS_EN: we=1, waddr=4, wdata=0x55, raddr1=4, rf_rdata1=0x0 -> fwd_rdata1=0x55. With raddr1=0 -> fwd_rdata1 = rf_rdata1.
